// File: rtl/irq_ctrl_if.sv
// Bus between the interrupt controller and its environment: raw request lines, mask port and core handshake.
// The ack_cnt/lost statistics signals exist only when IRQ_STAT_EN is defined.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_din;
  logic               int_ack;
  logic               int_done;
  logic               int_req;
  logic [ID_W-1:0]    int_id;
  logic               busy;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
`ifdef IRQ_STAT_EN
  logic [15:0]        ack_cnt;
  logic [NUM_SRC-1:0] lost;

  modport master (
    output irq_in, mask_we, mask_din, int_ack, int_done,
    input  int_req, int_id, busy, pending, mask, ack_cnt, lost
  );
  modport slave (
    input  irq_in, mask_we, mask_din, int_ack, int_done,
    output int_req, int_id, busy, pending, mask, ack_cnt, lost
  );
`else
  modport master (
    output irq_in, mask_we, mask_din, int_ack, int_done,
    input  int_req, int_id, busy, pending, mask
  );
  modport slave (
    input  irq_in, mask_we, mask_din, int_ack, int_done,
    output int_req, int_id, busy, pending, mask
  );
`endif
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: synchronises NUM_SRC request lines and runs the core accept/return handshake.
// Define IRQ_STAT_EN to add the ack_cnt and lost statistics outputs.
module irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2,
  parameter int EDGE    = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  irq_ctrl_if.slave irq_bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  state_e             state_q;
  logic               intReq_q;
  logic [ID_W-1:0]    intId_q;
  logic               busy_q;
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] sync3_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] effReq;
  logic [NUM_SRC-1:0] riseDet;
  logic [NUM_SRC-1:0] ackClr;
  logic [ID_W-1:0]    lowestId;
  logic               ackTaken;

  assign riseDet  = sync2_q & ~sync3_q;
  assign effReq   = pending_q & ~mask_q;
  assign ackTaken = (state_q == REQ) && irq_bus.int_ack;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq_bus.irq_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    ackClr = '0;
    if (ackTaken) ackClr[intId_q] = 1'b1;
  end

  // A new edge on the bit being acknowledged re-arms it rather than being swallowed.
  always_comb begin
    if (EDGE != 0) pending_d = (pending_q & ~ackClr) | riseDet;
    else           pending_d = sync2_q;
  end

  always_comb begin
    lowestId = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (effReq[i]) lowestId = ID_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (irq_bus.mask_we) mask_q <= irq_bus.mask_din;
    end
  end

  // int_id is frozen once offered; only a withdraw or an ack releases it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      intReq_q <= 1'b0;
      intId_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (effReq != '0) begin
            state_q  <= REQ;
            intReq_q <= 1'b1;
            intId_q  <= lowestId;
          end
        end
        REQ: begin
          if (irq_bus.int_ack) begin
            state_q  <= SERVICE;
            intReq_q <= 1'b0;
            busy_q   <= 1'b1;
          end else if (!effReq[intId_q]) begin
            state_q  <= IDLE;
            intReq_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_bus.int_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          intReq_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_bus.int_req = intReq_q;
  assign irq_bus.int_id  = intId_q;
  assign irq_bus.busy    = busy_q;
  assign irq_bus.pending = pending_q;
  assign irq_bus.mask    = mask_q;

`ifdef IRQ_STAT_EN
  logic [15:0]        ackCnt_q;
  logic [NUM_SRC-1:0] lost_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ackCnt_q <= '0;
      lost_q   <= '0;
    end else begin
      if (ackTaken && (ackCnt_q != 16'hFFFF)) ackCnt_q <= ackCnt_q + 16'd1;
      if (EDGE != 0) lost_q <= lost_q | (riseDet & pending_q & ~ackClr);
    end
  end

  assign irq_bus.ack_cnt = ackCnt_q;
  assign irq_bus.lost    = lost_q;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: edge- and level-mode instances, directed vector table plus randomised run against a reference model.
// Statistics checks are compiled in when IRQ_STAT_EN is defined.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] irqIn = '0;
  logic       maskWe = 1'b0;
  logic [3:0] maskDin = '0;
  logic       intAck = 1'b0;
  logic       intDone = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(4), .ID_W(2)) busE ();
  irq_ctrl_if #(.NUM_SRC(4), .ID_W(2)) busL ();

  assign busE.irq_in   = irqIn;
  assign busE.mask_we  = maskWe;
  assign busE.mask_din = maskDin;
  assign busE.int_ack  = intAck;
  assign busE.int_done = intDone;
  assign busL.irq_in   = irqIn;
  assign busL.mask_we  = maskWe;
  assign busL.mask_din = maskDin;
  assign busL.int_ack  = intAck;
  assign busL.int_done = intDone;

  irq_ctrl #(.NUM_SRC(4), .ID_W(2), .EDGE(1)) dutEdge (
    .clk_i  (clk),
    .rst_ni (rstN),
    .irq_bus(busE)
  );

  irq_ctrl #(.NUM_SRC(4), .ID_W(2), .EDGE(0)) dutLevel (
    .clk_i  (clk),
    .rst_ni (rstN),
    .irq_bus(busL)
  );

  // Reference model: index 0 is edge mode, 1 is level mode; -1 means "nothing offered / in service".
  logic [3:0] hist1, hist2, hist3;
  logic [3:0] mPend[2];
  logic [3:0] mMask[2];
  logic [3:0] mLost[2];
  int         mOffer[2];
  int         mServe[2];
  int         mLast[2];
  int         mAcks[2];

  typedef struct {
    int doRst;
    int lvl;
    int irq;
    int ack;
    int done;
    int eReq;
    int eId;
    int eBusy;
    int ePend;
  } vec_t;

  vec_t vecs[$];

  function automatic int lowestSet(input logic [3:0] v);
    int n;
    n = 0;
    if (v == 4'b0) return -1;
    while (n < 3 && v[n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [11:0] packE();
    return {busE.int_req, busE.int_id, busE.busy, busE.pending, busE.mask};
  endfunction

  function automatic logic [11:0] packL();
    return {busL.int_req, busL.int_id, busL.busy, busL.pending, busL.mask};
  endfunction

  function automatic logic [11:0] modelPack(input int m);
    return {mOffer[m] >= 0, 2'(mLast[m]), mServe[m] >= 0, mPend[m], mMask[m]};
  endfunction

  task automatic modelStep(input logic [3:0] irq, input logic we, input logic [3:0] din,
                           input logic ack, input logic done);
    logic [3:0] rise, eff, clr;
    rise = hist2 & ~hist3;
    for (int m = 0; m < 2; m++) begin
      eff = mPend[m] & ~mMask[m];
      clr = '0;
      if (mServe[m] >= 0) begin
        if (done) mServe[m] = -1;
      end else if (mOffer[m] >= 0) begin
        if (ack) begin
          mServe[m] = mOffer[m];
          mOffer[m] = -1;
          clr[mServe[m]] = 1'b1;
          if (mAcks[m] < 65535) mAcks[m]++;
        end else if (!eff[mOffer[m]]) begin
          mOffer[m] = -1;
        end
      end else if (eff != 4'b0) begin
        mOffer[m] = lowestSet(eff);
        mLast[m]  = mOffer[m];
      end
      if (m == 0) begin
        mLost[m] = mLost[m] | (rise & mPend[m] & ~clr);
        mPend[m] = (mPend[m] & ~clr) | rise;
      end else begin
        mPend[m] = hist2;
      end
      if (we) mMask[m] = din;
    end
    hist3 = hist2;
    hist2 = hist1;
    hist1 = irq;
  endtask

  task automatic resetDut();
    rstN    = 1'b0;
    irqIn   = '0;
    maskWe  = 1'b0;
    maskDin = '0;
    intAck  = 1'b0;
    intDone = 1'b0;
    repeat (2) @(posedge clk);
    hist1 = '0;
    hist2 = '0;
    hist3 = '0;
    for (int m = 0; m < 2; m++) begin
      mPend[m]  = '0;
      mMask[m]  = '0;
      mLost[m]  = '0;
      mOffer[m] = -1;
      mServe[m] = -1;
      mLast[m]  = 0;
      mAcks[m]  = 0;
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic we, input logic [3:0] din,
                               input logic ack, input logic done);
    irqIn   = irq;
    maskWe  = we;
    maskDin = din;
    intAck  = ack;
    intDone = done;
    @(posedge clk);
    #1;
    modelStep(irq, we, din, ack, done);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] irqCur;
    logic [11:0] got;

    // Fields: doRst, lvl, irq, ack, done, expected req, id, busy, pending.
    vecs.push_back('{1, 0, 'b0100, 0, 0, 0, 0, 0, 'b0000});
    vecs.push_back('{0, 0, 'b0100, 0, 0, 0, 0, 0, 'b0000});
    vecs.push_back('{0, 0, 'b0100, 0, 0, 0, 0, 0, 'b0100});
    vecs.push_back('{0, 0, 'b0000, 0, 0, 1, 2, 0, 'b0100});
    vecs.push_back('{0, 0, 'b0000, 1, 0, 0, 2, 1, 'b0000});
    vecs.push_back('{0, 0, 'b0000, 1, 0, 0, 2, 1, 'b0000});
    vecs.push_back('{0, 0, 'b0000, 0, 1, 0, 2, 0, 'b0000});
    vecs.push_back('{0, 0, 'b0000, 0, 1, 0, 2, 0, 'b0000});
    vecs.push_back('{0, 0, 'b1010, 0, 0, 0, 2, 0, 'b0000});
    vecs.push_back('{0, 0, 'b1010, 0, 0, 0, 2, 0, 'b0000});
    vecs.push_back('{0, 0, 'b1010, 0, 0, 0, 2, 0, 'b1010});
    vecs.push_back('{0, 0, 'b0000, 0, 0, 1, 1, 0, 'b1010});
    vecs.push_back('{0, 0, 'b0000, 1, 0, 0, 1, 1, 'b1000});
    vecs.push_back('{0, 0, 'b0000, 0, 1, 0, 1, 0, 'b1000});
    vecs.push_back('{0, 0, 'b0000, 0, 0, 1, 3, 0, 'b1000});
    vecs.push_back('{0, 0, 'b0001, 0, 1, 1, 3, 0, 'b1000});
    vecs.push_back('{0, 0, 'b0001, 0, 0, 1, 3, 0, 'b1000});
    vecs.push_back('{0, 0, 'b0001, 0, 0, 1, 3, 0, 'b1001});
    vecs.push_back('{0, 0, 'b0000, 0, 0, 1, 3, 0, 'b1001});
    vecs.push_back('{0, 0, 'b0000, 1, 0, 0, 3, 1, 'b0001});
    vecs.push_back('{0, 0, 'b0000, 0, 1, 0, 3, 0, 'b0001});
    vecs.push_back('{0, 0, 'b0000, 0, 0, 1, 0, 0, 'b0001});
    vecs.push_back('{0, 0, 'b0000, 1, 0, 0, 0, 1, 'b0000});
    vecs.push_back('{0, 0, 'b0000, 0, 1, 0, 0, 0, 'b0000});
    vecs.push_back('{0, 0, 'b0000, 1, 1, 0, 0, 0, 'b0000});
    vecs.push_back('{1, 1, 'b0010, 0, 0, 0, 0, 0, 'b0000});
    vecs.push_back('{0, 1, 'b0010, 0, 0, 0, 0, 0, 'b0000});
    vecs.push_back('{0, 1, 'b0010, 0, 0, 0, 0, 0, 'b0010});
    vecs.push_back('{0, 1, 'b0010, 0, 0, 1, 1, 0, 'b0010});
    vecs.push_back('{0, 1, 'b0010, 1, 0, 0, 1, 1, 'b0010});
    vecs.push_back('{0, 1, 'b0010, 0, 1, 0, 1, 0, 'b0010});
    vecs.push_back('{0, 1, 'b0010, 0, 0, 1, 1, 0, 'b0010});
    vecs.push_back('{0, 1, 'b0000, 1, 0, 0, 1, 1, 'b0010});
    vecs.push_back('{0, 1, 'b0000, 0, 0, 0, 1, 1, 'b0010});
    vecs.push_back('{0, 1, 'b0000, 0, 0, 0, 1, 1, 'b0000});
    vecs.push_back('{0, 1, 'b0000, 0, 1, 0, 1, 0, 'b0000});
    vecs.push_back('{0, 1, 'b0000, 0, 0, 0, 1, 0, 'b0000});
    vecs.push_back('{0, 1, 'b0000, 0, 0, 0, 1, 0, 'b0000});

    $display("[TB] reset state");
    resetDut();
    checkOutput("resetEdge", 32'(packE()), 32'd0);
    checkOutput("resetLevel", 32'(packL()), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doRst != 0) resetDut();
      applyStimulus(4'(vecs[i].irq), 1'b0, 4'b0, vecs[i].ack != 0, vecs[i].done != 0);
      got = (vecs[i].lvl != 0) ? packL() : packE();
      checkOutput($sformatf("vec%0d", i), 32'(got >> 4),
                  32'((vecs[i].eReq << 7) | (vecs[i].eId << 5) | (vecs[i].eBusy << 4) | vecs[i].ePend));
    end

    $display("[TB] mask withdraw sequence");
    resetDut();
    applyStimulus(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    checkOutput("maskOffer", 32'(packE()), 32'({1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000}));
    applyStimulus(4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0);
    checkOutput("maskWrite", 32'(packE()), 32'({1'b1, 2'd2, 1'b0, 4'b0100, 4'b0100}));
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    checkOutput("maskWithdraw", 32'(packE()), 32'({1'b0, 2'd2, 1'b0, 4'b0100, 4'b0100}));
    applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("maskClear", 32'(packE()), 32'({1'b0, 2'd2, 1'b0, 4'b0100, 4'b0000}));
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    checkOutput("maskReoffer", 32'(packE()), 32'({1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000}));
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
    checkOutput("maskAck", 32'(packE()), 32'({1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000}));

    $display("[TB] reset during service");
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
    checkOutput("busyPending", 32'(packE()), 32'({1'b0, 2'd2, 1'b1, 4'b0001, 4'b0000}));
    rstN = 1'b0;
    #2;
    checkOutput("asyncRstEdge", 32'(packE()), 32'd0);
    checkOutput("asyncRstLevel", 32'(packL()), 32'd0);
    resetDut();

`ifdef IRQ_STAT_EN
    $display("[TB] lost edge sequence");
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
    checkOutput("lostEdgeDirected", 32'(busE.lost), 32'(4'b0001));
    checkOutput("lostLevelDirected", 32'(busL.lost), 32'd0);
    applyStimulus(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
    checkOutput("ackCntOne", 32'(busE.ack_cnt), 32'd1);
`endif

    $display("[TB] randomised run");
    irqCur = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irqCur = 4'($urandom_range(0, 15));
      applyStimulus(irqCur, $urandom_range(0, 11) == 0,
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      checkOutput($sformatf("randEdge%0d", c), 32'(packE()), 32'(modelPack(0)));
      checkOutput($sformatf("randLevel%0d", c), 32'(packL()), 32'(modelPack(1)));
    end

`ifdef IRQ_STAT_EN
    checkOutput("ackCntEdge", 32'(busE.ack_cnt), 32'(mAcks[0]));
    checkOutput("ackCntLevel", 32'(busL.ack_cnt), 32'(mAcks[1]));
    checkOutput("lostEdge", 32'(busE.lost), 32'(mLost[0]));
    checkOutput("lostLevel", 32'(busL.lost), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
